multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle RISC core. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath write enable and the 2-bit `pcsrc` mux select, and resolves conditional branches from the ALU `carry`/`zero` flags. It owns the CALL/RET return-address stack, implemented in its `ret_stack` sub-module.

## Interface
- `ADDR_W`, 16: PC / return-address width
- `RS_DEPTH`, 8: return-stack entries (power of two, ≥2)
- `clk` in 1: the single clock; all state updates on the rising edge
- `reset_n` in 1: reset, asynchronous and active-low
- `opcode` in 6: from the instruction register, valid from DECODE onward
- `carry`, `zero` in 1 each: ALU flags, valid during EXEC_BR
- `mem_ready` in 1: data-memory handshake completion
- `pc_in` in ADDR_W: current PC value, pushed on CALL
- `pc_we` out 1: PC load
- `ir_we` out 1: instruction-register load
- `rf_we` out 1: register-file write
- `mem_rd`, `mem_wr` out 1 each: data-memory strobes
- `alu_src_imm` out 1: 1 = ALU operand B is the immediate
- `wb_sel` out 1: 0 = ALU result, 1 = memory data
- `pcsrc` out 2: 0 = PC+1, 1 = jump target, 2 = branch target, 3 = `ret_addr`
- `ret_addr` out ADDR_W: top of the return stack
- `state` out 4: current state, for debug
- `fault` out 1: sticky illegal-instruction / stack-error flag

## Operation
- Opcode map: 0–3 ALU R-type; 4–5 ALU immediate; 6 LW; 7 SW; 8 BGT; 9 BLT; 10 BEQ; 11 BNE; 12 JMP; 13 CALL; 14 RET; 15–63 illegal.
- States: FETCH, DECODE, EXEC_ALU, EXEC_ADDR, EXEC_BR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, FAULT.
- FETCH: assert `ir_we=1`, `pc_we=1`, `pcsrc=0`, then go to DECODE.
- DECODE, by opcode:
  - ALU → EXEC_ALU.
  - LW/SW → EXEC_ADDR.
  - Branch → EXEC_BR.
  - JMP: `pc_we=1`, `pcsrc=1`, → FETCH.
  - CALL: push `pc_in` (already PC+1), `pc_we=1`, `pcsrc=1`, → FETCH.
  - RET: `pc_we=1`, `pcsrc=3`, pop, → FETCH.
  - Illegal → FAULT.
- EXEC_ALU: `alu_src_imm=1` for opcodes 4–5, then → WB_ALU.
- WB_ALU: `rf_we=1`, `wb_sel=0`, → FETCH.
- EXEC_ADDR: `alu_src_imm=1`; LW → MEM_RD, SW → MEM_WR.
- MEM_RD: hold `mem_rd=1` until `mem_ready=1`, then → WB_MEM.
- WB_MEM: `rf_we=1`, `wb_sel=1`, → FETCH.
- MEM_WR: hold `mem_wr=1` until `mem_ready=1`, then → FETCH.
- EXEC_BR: a branch is taken when:
  - BGT: `carry=1` and `zero=0`
  - BLT: `carry=0` and `zero=0`
  - BEQ: `zero=1`
  - BNE: `zero=0`
- If taken: `pc_we=1`, `pcsrc=2`. Always → FETCH.
- FAULT: terminal. All enables stay 0 and `fault=1` until reset.
- Every output not named in a state is 0 in that state.

## Timing
- Moore outputs, decoded from registered state. The only exception is the branch-taken `pc_we`, which is combinational on `carry`/`zero` within EXEC_BR.
- Cycles per instruction (no memory wait): JMP/CALL/RET 2; branch 3; ALU 4; SW 4; LW 5.
- Each cycle `mem_ready` is low in MEM_RD/MEM_WR adds one cycle. There is no timeout.
- The strobe (`mem_rd`/`mem_wr`) deasserts in the cycle after `mem_ready` is sampled high.
- Return stack:
  - A push writes at the DECODE clock edge.
  - `ret_addr` is combinational from the top entry, so RET uses the pre-pop top.
  - A pop takes effect at the same edge.
  - A push and a pop never occur in the same cycle.
- Reset:
  - Asynchronously forces state FETCH, stack pointer 0, `fault=0`, all outputs 0.
  - The first FETCH begins on the first edge after `reset_n` rises.
  - Reset asserted mid-LW drops `mem_rd` immediately.

## Configuration
- `CTRL_RS_GUARD_EN` defined:
  - CALL with the stack full, or RET with the stack empty, goes to FAULT instead of FETCH.
  - `pc_we` and the stack stay unchanged in that cycle.
- Not defined:
  - The stack is circular. The pointer wraps modulo RS_DEPTH, so push-on-full overwrites the oldest entry.
  - RET on empty returns whatever the wrapped slot holds, with no fault.
  - `fault` is raised only by illegal opcodes.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - opcode constants: OP_LW=6, OP_SW=7, OP_BGT=8 … OP_RET=14
  - pcsrc encodings: PCSRC_NEXT=0, PCSRC_JUMP=1, PCSRC_BRANCH=2, PCSRC_RET=3
- Sub-module `ret_stack`, parameterised by ADDR_W and RS_DEPTH. Ports: push, pop, din, top, full, empty. It contains the register array and the pointer.

## Test plan
- Reset, then ADD (opcode 0) → states FETCH, DECODE, EXEC_ALU, WB_ALU, FETCH; `rf_we=1` in exactly one cycle with `wb_sel=0`.
- LW with `mem_ready` held low 3 cycles → `mem_rd` high for 4 cycles; `rf_we`/`wb_sel=1` in the next cycle; 8 cycles total.
- Branch flags:
  - BEQ with `zero=1` → `pc_we=1`, `pcsrc=2` in EXEC_BR.
  - BGT with `carry=1`, `zero=1` → `pc_we=0`.
  - BLT with `carry=0`, `zero=0` → taken.
- Nested calls: CALL at `pc_in`=0x0011, CALL at 0x0021, RET, RET → `ret_addr` is 0x0021 then 0x0011 while `pcsrc=3`.
- With `CTRL_RS_GUARD_EN`: RS_DEPTH+1 consecutive CALLs → the final one enters FAULT with `fault=1`. Without the macro: it wraps, no fault.
- Opcode 15 → FAULT, with all enables held 0 for 10 cycles; assert `reset_n=0` mid-MEM_WR → `mem_wr` drops at once.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle core control FSM.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned PCSRC_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_ALU  = 4'd2,
    EXEC_ADDR = 4'd3,
    EXEC_BR   = 4'd4,
    MEM_RD    = 4'd5,
    MEM_WR    = 4'd6,
    WB_ALU    = 4'd7,
    WB_MEM    = 4'd8,
    FAULT     = 4'd9
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ALU_IMM = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_LW      = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_SW      = 6'd7;
  localparam logic [OPCODE_W-1:0] OP_BGT     = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_BLT     = 6'd9;
  localparam logic [OPCODE_W-1:0] OP_BEQ     = 6'd10;
  localparam logic [OPCODE_W-1:0] OP_BNE     = 6'd11;
  localparam logic [OPCODE_W-1:0] OP_JMP     = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_CALL    = 6'd13;
  localparam logic [OPCODE_W-1:0] OP_RET     = 6'd14;

  localparam logic [PCSRC_W-1:0] PCSRC_NEXT   = 2'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 2'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_RET    = 2'd3;

  function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
    return op < OP_LW;
  endfunction

  function automatic logic is_alu_imm(input logic [OPCODE_W-1:0] op);
    return (op >= OP_ALU_IMM) && (op < OP_LW);
  endfunction

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op >= OP_BGT) && (op <= OP_BNE);
  endfunction

  // Condition evaluation on the flags of the compare done in EXEC_BR
  function automatic logic branch_taken(input logic [OPCODE_W-1:0] op,
                                        input logic carry, input logic zero);
    logic t;
    t = 1'b0;
    case (op)
      OP_BGT:  t = carry & ~zero;
      OP_BLT:  t = ~carry & ~zero;
      OP_BEQ:  t = zero;
      OP_BNE:  t = ~zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_ret_stack.sv
// CALL/RET return-address stack: register array plus a wrapping pointer and an
// occupancy count that provides full/empty.
module ret_stack #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign top   = mem_q[sp_q - PTR_W'(1)];
  assign full  = (cnt_q == CNT_W'(RS_DEPTH));
  assign empty = (cnt_q == '0);

  // Pointer always wraps; the count saturates so full/empty stay meaningful
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[sp_q] = din;
      sp_d        = sp_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_d = sp_q - PTR_W'(1);
      if (!empty) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) mem_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core (fetch/decode/execute/memory/write-back).
// Define CTRL_RS_GUARD_EN to trap return-stack overflow/underflow into FAULT.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                pc_we,
  output logic                ir_we,
  output logic                rf_we,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                alu_src_imm,
  output logic                wb_sel,
  output logic [PCSRC_W-1:0]  pcsrc,
  output logic [ADDR_W-1:0]   ret_addr,
  output logic [STATE_W-1:0]  state,
  output logic                fault
);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   fault_q, fault_d;
  logic   rs_push, rs_pop, rs_full, rs_empty;

  ret_stack #(.ADDR_W(ADDR_W), .RS_DEPTH(RS_DEPTH)) u_ret_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rs_push),
    .pop     (rs_pop),
    .din     (pc_in),
    .top     (ret_addr),
    .full    (rs_full),
    .empty   (rs_empty)
  );

`ifndef CTRL_RS_GUARD_EN
  logic rs_flags_unused;
  assign rs_flags_unused = rs_full ^ rs_empty;
`endif

  assign state = state_q;
  assign fault = fault_q;

  // run_q holds off the first FETCH until the first edge after reset release
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    pcsrc       = PCSRC_NEXT;
    rs_push     = 1'b0;
    rs_pop      = 1'b0;
    if (!run_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
        DECODE: begin
          if (is_alu(opcode)) begin
            state_d = EXEC_ALU;
          end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            state_d = EXEC_ADDR;
          end else if (is_branch(opcode)) begin
            state_d = EXEC_BR;
          end else if (opcode == OP_JMP) begin
            pc_we   = 1'b1;
            pcsrc   = PCSRC_JUMP;
            state_d = FETCH;
          end else if (opcode == OP_CALL) begin
`ifdef CTRL_RS_GUARD_EN
            if (rs_full) begin
              state_d = FAULT;
            end else begin
              rs_push = 1'b1;
              pc_we   = 1'b1;
              pcsrc   = PCSRC_JUMP;
              state_d = FETCH;
            end
`else
            rs_push = 1'b1;
            pc_we   = 1'b1;
            pcsrc   = PCSRC_JUMP;
            state_d = FETCH;
`endif
          end else if (opcode == OP_RET) begin
`ifdef CTRL_RS_GUARD_EN
            if (rs_empty) begin
              state_d = FAULT;
            end else begin
              rs_pop  = 1'b1;
              pc_we   = 1'b1;
              pcsrc   = PCSRC_RET;
              state_d = FETCH;
            end
`else
            rs_pop  = 1'b1;
            pc_we   = 1'b1;
            pcsrc   = PCSRC_RET;
            state_d = FETCH;
`endif
          end else begin
            state_d = FAULT;
          end
        end
        EXEC_ALU: begin
          alu_src_imm = is_alu_imm(opcode);
          state_d     = WB_ALU;
        end
        WB_ALU: begin
          rf_we   = 1'b1;
          state_d = FETCH;
        end
        EXEC_ADDR: begin
          alu_src_imm = 1'b1;
          state_d     = (opcode == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_rd = 1'b1;
          if (mem_ready) state_d = WB_MEM;
        end
        WB_MEM: begin
          rf_we   = 1'b1;
          wb_sel  = 1'b1;
          state_d = FETCH;
        end
        MEM_WR: begin
          mem_wr = 1'b1;
          if (mem_ready) state_d = FETCH;
        end
        EXEC_BR: begin
          if (branch_taken(opcode, carry, zero)) begin
            pc_we = 1'b1;
            pcsrc = PCSRC_BRANCH;
          end
          state_d = FETCH;
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
    fault_d = fault_q | (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations are queued with
// their stimulus and compared against the DUT outputs one cycle at a time.
module tb_multicycle_ctrl;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned RS_DEPTH = 8;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_EXEC_ALU = 4'd2,
                         T_EXEC_ADDR = 4'd3, T_EXEC_BR = 4'd4, T_MEM_RD = 4'd5,
                         T_MEM_WR = 4'd6, T_WB_ALU = 4'd7, T_WB_MEM = 4'd8,
                         T_FAULT = 4'd9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [5:0]        opcode = '0;
  logic              carry = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [ADDR_W-1:0] pc_in = '0;
  logic              pc_we, ir_we, rf_we, mem_rd, mem_wr, alu_src_imm, wb_sel, fault;
  logic [1:0]        pcsrc;
  logic [ADDR_W-1:0] ret_addr;
  logic [3:0]        state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic        c;
    logic        z;
    logic        rdy;
    logic [15:0] pc;
    logic [13:0] exp;
    logic        chk_ret;
    logic [15:0] ret;
  } cyc_t;

  cyc_t        sb[$];
  logic [15:0] stk[$];

  multicycle_ctrl #(.ADDR_W(ADDR_W), .RS_DEPTH(RS_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .carry(carry), .zero(zero),
    .mem_ready(mem_ready), .pc_in(pc_in), .pc_we(pc_we), .ir_we(ir_we),
    .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_src_imm(alu_src_imm),
    .wb_sel(wb_sel), .pcsrc(pcsrc), .ret_addr(ret_addr), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [13:0] mk(input logic [3:0] st, input logic f, input logic pcwe,
                                     input logic irwe, input logic rfwe, input logic mrd,
                                     input logic mwr, input logic imm, input logic wb,
                                     input logic [1:0] pcs);
    return {st, f, pcwe, irwe, rfwe, mrd, mwr, imm, wb, pcs};
  endfunction

  function automatic logic [13:0] obs();
    return {state, fault, pc_we, ir_we, rf_we, mem_rd, mem_wr, alu_src_imm, wb_sel, pcsrc};
  endfunction

  function automatic void add(input logic [5:0] op, input logic c, input logic z,
                              input logic rdy, input logic [15:0] pc, input logic [13:0] e,
                              input logic chk, input logic [15:0] r);
    cyc_t x;
    x = '{op: op, c: c, z: z, rdy: rdy, pc: pc, exp: e, chk_ret: chk, ret: r};
    sb.push_back(x);
  endfunction

  // Reference model: expected per-cycle outputs of one instruction
  function automatic void add_instr(input logic [5:0] op, input logic c, input logic z,
                                    input logic [15:0] pc, input int waits);
    logic t;
    logic [15:0] r;
    add(op, c, z, 1'b0, pc, mk(T_FETCH, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    if (op <= 6'd5) begin
      add(op, c, z, 1'b0, pc, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
      add(op, c, z, 1'b0, pc, mk(T_EXEC_ALU, 0, 0, 0, 0, 0, 0, (op >= 6'd4), 0, 2'd0), 1'b0, 16'h0);
      add(op, c, z, 1'b0, pc, mk(T_WB_ALU, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    end else if (op == 6'd6 || op == 6'd7) begin
      add(op, c, z, 1'b0, pc, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
      add(op, c, z, 1'b0, pc, mk(T_EXEC_ADDR, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), 1'b0, 16'h0);
      for (int i = 0; i <= waits; i++)
        add(op, c, z, (i == waits), pc,
            (op == 6'd6) ? mk(T_MEM_RD, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0)
                         : mk(T_MEM_WR, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0), 1'b0, 16'h0);
      if (op == 6'd6)
        add(op, c, z, 1'b0, pc, mk(T_WB_MEM, 0, 0, 0, 1, 0, 0, 0, 1, 2'd0), 1'b0, 16'h0);
    end else if (op >= 6'd8 && op <= 6'd11) begin
      case (op)
        6'd8:    t = c && !z;
        6'd9:    t = !c && !z;
        6'd10:   t = z;
        default: t = !z;
      endcase
      add(op, c, z, 1'b0, pc, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
      add(op, c, z, 1'b0, pc, mk(T_EXEC_BR, 0, t, 0, 0, 0, 0, 0, 0, t ? 2'd2 : 2'd0), 1'b0, 16'h0);
    end else if (op == 6'd12 || op == 6'd13) begin
      if (op == 6'd13) begin
        stk.push_back(pc);
        if (stk.size() > RS_DEPTH) void'(stk.pop_front());
      end
      add(op, c, z, 1'b0, pc, mk(T_DECODE, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1), 1'b0, 16'h0);
    end else if (op == 6'd14) begin
      r = stk.pop_back();
      add(op, c, z, 1'b0, pc, mk(T_DECODE, 0, 1, 0, 0, 0, 0, 0, 0, 2'd3), 1'b1, r);
    end
  endfunction

  task automatic drive_next(output cyc_t c);
    c = sb.pop_front();
    @(negedge clk);
    opcode = c.op; carry = c.c; zero = c.z; mem_ready = c.rdy; pc_in = c.pc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stk.delete();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs() !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs(), 14'h0);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault: got %b want 0", fault);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    cyc_t c;
    int n = 0;
    add_instr(6'd0, 0, 0, 16'h0001, 0);
    add_instr(6'd4, 0, 0, 16'h0002, 0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL alu cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
  endtask

  task automatic test_load_store();
    cyc_t c;
    int n = 0;
    add_instr(6'd6, 0, 0, 16'h0003, 3);
    add_instr(6'd7, 0, 0, 16'h0004, 0);
    add_instr(6'd6, 0, 0, 16'h0005, 0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL load_store cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    int n = 0;
    add_instr(6'd10, 0, 1, 16'h0006, 0);
    add_instr(6'd8,  1, 1, 16'h0007, 0);
    add_instr(6'd9,  0, 0, 16'h0008, 0);
    add_instr(6'd11, 1, 1, 16'h0009, 0);
    add_instr(6'd8,  1, 0, 16'h000a, 0);
    add_instr(6'd10, 1, 0, 16'h000b, 0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL branch cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
  endtask

  task automatic test_call_ret();
    cyc_t c;
    int n = 0;
    add_instr(6'd12, 0, 0, 16'h000c, 0);
    add_instr(6'd13, 0, 0, 16'h0011, 0);
    add_instr(6'd13, 0, 0, 16'h0021, 0);
    add_instr(6'd14, 0, 0, 16'h0030, 0);
    add_instr(6'd14, 0, 0, 16'h0031, 0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL call_ret cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      if (c.chk_ret) begin
        checks++;
        if (ret_addr !== c.ret) begin
          errors++; $display("FAIL call_ret ret_addr cyc %0d: got %h want %h", n, ret_addr, c.ret);
        end
      end
      n++;
    end
  endtask

  task automatic test_stack_depth();
    cyc_t c;
    int n = 0;
    for (int i = 0; i < int'(RS_DEPTH); i++)
      add_instr(6'd13, 0, 0, 16'h0100 + 16'(i), 0);
`ifdef CTRL_RS_GUARD_EN
    add(6'd13, 0, 0, 0, 16'h0108, mk(T_FETCH, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    add(6'd13, 0, 0, 0, 16'h0108, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    for (int i = 0; i < 3; i++)
      add(6'd13, 0, 0, 0, 16'h0108, mk(T_FAULT, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
`else
    add_instr(6'd13, 0, 0, 16'h0108, 0);
    add_instr(6'd14, 0, 0, 16'h0200, 0);
    add_instr(6'd14, 0, 0, 16'h0201, 0);
`endif
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL stack_depth cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      if (c.chk_ret) begin
        checks++;
        if (ret_addr !== c.ret) begin
          errors++; $display("FAIL stack_depth ret_addr cyc %0d: got %h want %h", n, ret_addr, c.ret);
        end
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    int n = 0;
    add(6'd15, 0, 0, 0, 16'h0, mk(T_FETCH, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    add(6'd15, 0, 0, 0, 16'h0, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    for (int i = 0; i < 10; i++)
      add(6'd6, 1, 0, 1, 16'h0, mk(T_FAULT, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL illegal cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_wr();
    cyc_t c;
    int n = 0;
    add(6'd7, 0, 0, 0, 16'h0, mk(T_FETCH, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    add(6'd7, 0, 0, 0, 16'h0, mk(T_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0, 16'h0);
    add(6'd7, 0, 0, 0, 16'h0, mk(T_EXEC_ADDR, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0), 1'b0, 16'h0);
    add(6'd7, 0, 0, 0, 16'h0, mk(T_MEM_WR, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0), 1'b0, 16'h0);
    add(6'd7, 0, 0, 0, 16'h0, mk(T_MEM_WR, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0), 1'b0, 16'h0);
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL mid_wr cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 14'h0) begin
      errors++; $display("FAIL mid_wr_async_reset: got %h want %h", obs(), 14'h0);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    stk.delete();
    add_instr(6'd12, 0, 0, 16'h0040, 0);
    n = 0;
    while (sb.size() != 0) begin
      drive_next(c);
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL restart cyc %0d: got %h want %h", n, obs(), c.exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_call_ret();
    test_stack_depth();
    test_reset();
    test_illegal();
    test_reset();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
